// File: rtl/fetch_sequencer.sv
// Program sequencer for the 9-bit accumulator core.
// Owns ProgCtr, decoder mode, PrevInstruction, the CMP flags and the Start/Done handshake.
module fetch_sequencer #(
  parameter int unsigned PC_W       = 9,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned PROG_LEN   = 512,
  parameter int unsigned SKIP       = 2
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [8:0]      Instruction,
  input  logic [1:0]      NextState,
  input  logic            BranchEn,
  input  logic            CMPLoadEn,
  input  logic [2:0]      CmpIn,
  input  logic            Ack,
  output logic [PC_W-1:0] ProgCtr,
  output logic [1:0]      CurrState,
  output logic [8:0]      PrevInstruction,
  output logic [2:0]      CMPBits,
  output logic            Done,
  output logic            Overrun
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    M_REG = 2'b00,
    M_TGT = 2'b01,
    M_IMM = 2'b10,
    M_NOP = 2'b11
  } mode_t;

  state_t          r_state;
  mode_t           r_mode;
  logic [PC_W-1:0] r_pc;
  logic [8:0]      r_prev;
  logic [2:0]      r_cmp;
  logic            r_done;
  logic            r_overrun;

  logic [PC_W-1:0] w_pc_next;
  mode_t           w_mode_next;
  logic            w_ack;
  logic            w_overrun;

  always_comb begin
    w_pc_next   = r_pc;
    w_mode_next = M_REG;
    w_ack       = 1'b0;
    case (r_mode)
      M_REG: begin
        if (Ack) begin
          w_ack = 1'b1;
        end else if (BranchEn) begin
          w_pc_next = r_pc + PC_W'(SKIP);
        end else begin
          w_pc_next   = r_pc + PC_W'(1);
          w_mode_next = mode_t'(NextState);
        end
      end
      M_TGT: begin
        // Operand word: absolute target only when the preceding word was a branch.
        if (r_prev[8]) w_pc_next = PC_W'(Instruction);
        else           w_pc_next = r_pc + PC_W'(1);
      end
      default: w_pc_next = r_pc + PC_W'(1);
    endcase
    // Widened compare so PROG_LEN may equal 2^PC_W (overrun then never fires).
    w_overrun = !w_ack && (32'(w_pc_next) >= PROG_LEN);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_mode    <= M_REG;
      r_pc      <= PC_W'(START_ADDR);
      r_prev    <= '0;
      r_cmp     <= '0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else if (Start) begin
      r_state   <= S_RUN;
      r_mode    <= M_REG;
      r_pc      <= PC_W'(START_ADDR);
      r_prev    <= '0;
      r_cmp     <= '0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_prev <= Instruction;
      if (CMPLoadEn) r_cmp <= CmpIn;
      if (w_ack) begin
        r_state <= S_HALT;
        r_done  <= 1'b1;
      end else begin
        r_pc   <= w_pc_next;
        r_mode <= w_mode_next;
        if (w_overrun) begin
          r_state   <= S_HALT;
          r_done    <= 1'b1;
          r_overrun <= 1'b1;
        end
      end
    end
  end

  assign ProgCtr         = r_pc;
  assign CurrState       = r_mode;
  assign PrevInstruction = r_prev;
  assign CMPBits         = r_cmp;
  assign Done            = r_done;
  assign Overrun         = r_overrun;

endmodule
